// File: rtl/dice_dispatch_pkg.sv
// Shared dispatcher constants and the per-lane next-thread state encoding.
// The lane-reroute stage imports the same TID_W so ID widths stay consistent.
package dice_dispatch_pkg;

  localparam int TID_W                = 8;
  localparam int NUM_THREADS_PER_LANE = 256;
  localparam int SCAN_GROUP_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } lane_state_t;

endpackage

// File: rtl/lsb_prienc.sv
// Lowest-set-bit priority encoder over a W-bit vector.
// index is meaningful only when found is high.
module lsb_prienc #(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  bits,
  output logic [IW-1:0] index,
  output logic          found
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = {IW{1'b0}};
    for (int i = W - 1; i >= 0; i--) begin
      index = bits[i] ? IW'(i) : index;
    end
    found = |bits;
  end

endmodule

// File: rtl/next_active_thread_lane.sv
// Per-lane next-thread generator: captures a chunk's active mask and presents
// active thread IDs in ascending order, advancing on each downstream update.
module next_active_thread_lane #(
  parameter int NUM_THREADS = dice_dispatch_pkg::NUM_THREADS_PER_LANE,
  parameter int GROUP_W     = dice_dispatch_pkg::SCAN_GROUP_W,
  parameter int TID_W       = dice_dispatch_pkg::TID_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_THREADS-1:0] active_mask,
  input  logic                   update,
  output logic [TID_W-1:0]       next_tid,
  output logic                   valid,
  output logic                   busy,
  output logic                   done
);

  import dice_dispatch_pkg::*;

  localparam int NUM_GROUPS = NUM_THREADS / GROUP_W;
  localparam int CUR_W      = $clog2(NUM_GROUPS);
  localparam int BIT_W      = $clog2(GROUP_W);
  localparam logic [CUR_W-1:0] LAST_GROUP = CUR_W'(NUM_GROUPS - 1);

  lane_state_t            state;
  logic [NUM_THREADS-1:0] remaining;
  logic [CUR_W-1:0]       cursor;

  logic [GROUP_W-1:0] group;
  logic [GROUP_W-1:0] above;
  logic [GROUP_W-1:0] fast_bits;
  logic [BIT_W-1:0]   scan_idx;
  logic [BIT_W-1:0]   fast_idx;
  logic               scan_found;
  logic               fast_found;
  logic               last_group;

  // Select the cursor's group and mask off bits at or below the held ID.
  always_comb begin
    group = {GROUP_W{1'b0}};
    for (int g = 0; g < NUM_GROUPS; g++) begin
      group = (cursor == CUR_W'(g)) ? remaining[g*GROUP_W +: GROUP_W] : group;
    end
    for (int i = 0; i < GROUP_W; i++) begin
      above[i] = (BIT_W'(i) > next_tid[BIT_W-1:0]);
    end
    fast_bits  = group & above;
    last_group = (cursor == LAST_GROUP);
  end

  lsb_prienc #(.W(GROUP_W), .IW(BIT_W)) u_scan_enc (
    .bits  (group),
    .index (scan_idx),
    .found (scan_found)
  );

  lsb_prienc #(.W(GROUP_W), .IW(BIT_W)) u_fast_enc (
    .bits  (fast_bits),
    .index (fast_idx),
    .found (fast_found)
  );

  // Lane FSM with registered outputs; start overrides every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= {NUM_THREADS{1'b0}};
      cursor    <= {CUR_W{1'b0}};
      next_tid  <= {TID_W{1'b0}};
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      state     <= SCAN;
      remaining <= active_mask;
      cursor    <= {CUR_W{1'b0}};
      valid     <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        SCAN: begin
          if (scan_found) begin
            next_tid <= {cursor, scan_idx};
            valid    <= 1'b1;
            state    <= HOLD;
          end else if (last_group) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cursor <= cursor + 1'b1;
          end
        end
        HOLD: begin
          if (update && valid) begin
            remaining[next_tid] <= 1'b0;
            if (fast_found) begin
              next_tid <= {cursor, fast_idx};
            end else if (last_group) begin
              valid <= 1'b0;
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              valid  <= 1'b0;
              cursor <= cursor + 1'b1;
              state  <= SCAN;
            end
          end else begin
            state <= HOLD;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_next_active_thread_lane.sv
// Directed bench for next_active_thread_lane: cycle-exact latency, ordering,
// start priority and asynchronous reset checks with hand-computed expectations.
module tb_next_active_thread_lane;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] active_mask;
  logic         update;
  logic [7:0]   next_tid;
  logic         valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  next_active_thread_lane dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .active_mask (active_mask),
    .update      (update),
    .next_tid    (next_tid),
    .valid       (valid),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the given mask; returns positioned at cycle 1 of the chunk.
  task automatic do_start(input logic [255:0] m);
    active_mask = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [255:0] m;
    int idx;
    int bubbles;

    rst_n = 1'b0;
    start = 1'b0;
    update = 1'b0;
    active_mask = 256'd0;
    #12;
    check("rst_tid", 32'(next_tid), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Test 1: bits {0,1,2}, update high from first valid
    m = 256'd7;
    do_start(m);
    check("t1_c1_valid", 32'(valid), 32'd0);
    check("t1_c1_busy", 32'(busy), 32'd1);
    step();
    check("t1_id0_valid", 32'(valid), 32'd1);
    check("t1_id0", 32'(next_tid), 32'd0);
    update = 1'b1;
    step();
    check("t1_id1_valid", 32'(valid), 32'd1);
    check("t1_id1", 32'(next_tid), 32'd1);
    step();
    check("t1_id2_valid", 32'(valid), 32'd1);
    check("t1_id2", 32'(next_tid), 32'd2);
    step();
    check("t1_after_valid", 32'(valid), 32'd0);
    update = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("t1_c19_done", 32'(done), 32'd0);
    step();
    check("t1_c20_done", 32'(done), 32'd1);
    check("t1_c20_busy", 32'(busy), 32'd0);
    check("t1_c20_valid", 32'(valid), 32'd0);

    // Test 2: bit 200 only, no update
    m = 256'd0;
    m[200] = 1'b1;
    do_start(m);
    check("t2_done_cleared", 32'(done), 32'd0);
    for (int i = 0; i < 12; i++) step();
    check("t2_c13_valid", 32'(valid), 32'd0);
    step();
    check("t2_c14_valid", 32'(valid), 32'd1);
    check("t2_c14_tid", 32'(next_tid), 32'd200);
    for (int i = 0; i < 20; i++) begin
      step();
      check("t2_hold_valid", 32'(valid), 32'd1);
      check("t2_hold_tid", 32'(next_tid), 32'd200);
    end

    // Test 3: bits {15,16}, update always high
    m = 256'd0;
    m[15] = 1'b1;
    m[16] = 1'b1;
    update = 1'b1;
    do_start(m);
    check("t3_c1_valid", 32'(valid), 32'd0);
    step();
    check("t3_c2_valid", 32'(valid), 32'd1);
    check("t3_c2_tid", 32'(next_tid), 32'd15);
    step();
    check("t3_bubble", 32'(valid), 32'd0);
    step();
    check("t3_c4_valid", 32'(valid), 32'd1);
    check("t3_c4_tid", 32'(next_tid), 32'd16);
    step();
    check("t3_c5_valid", 32'(valid), 32'd0);
    update = 1'b0;

    // Test 4: empty mask
    do_start(256'd0);
    for (int c = 1; c <= 16; c++) begin
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_valid", 32'(valid), 32'd0);
      check("t4_done", 32'(done), 32'd0);
      step();
    end
    check("t4_c17_done", 32'(done), 32'd1);
    check("t4_c17_busy", 32'(busy), 32'd0);
    check("t4_c17_valid", 32'(valid), 32'd0);

    // Test 5: bits {3,9}; update while valid=0, then start overrides update
    m = 256'd0;
    m[3] = 1'b1;
    m[9] = 1'b1;
    do_start(m);
    update = 1'b1;
    step();
    check("t5_first_valid", 32'(valid), 32'd1);
    check("t5_first_tid", 32'(next_tid), 32'd3);
    step();
    check("t5_second_valid", 32'(valid), 32'd1);
    check("t5_second_tid", 32'(next_tid), 32'd9);
    update = 1'b0;
    step();
    check("t5_hold_tid", 32'(next_tid), 32'd9);
    m = 256'd0;
    m[5] = 1'b1;
    update = 1'b1;
    do_start(m);
    update = 1'b0;
    check("t5_restart_valid", 32'(valid), 32'd0);
    check("t5_restart_busy", 32'(busy), 32'd1);
    step();
    check("t5_new_valid", 32'(valid), 32'd1);
    check("t5_new_tid", 32'(next_tid), 32'd5);

    // Test 6: all ones, async reset mid-chunk, then full 256-ID run
    m = '1;
    do_start(m);
    step();
    update = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t6a_tid", 32'(next_tid), 32'(i));
      check("t6a_valid", 32'(valid), 32'd1);
      step();
    end
    update = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_tid", 32'(next_tid), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    step();
    step();
    check("t6_rst_hold_valid", 32'(valid), 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    do_start(m);
    step();
    update = 1'b1;
    idx = 0;
    bubbles = 0;
    for (int cyc = 0; cyc < 600 && idx < 256; cyc++) begin
      if (valid) begin
        check("t6b_tid", 32'(next_tid), 32'(idx));
        idx++;
      end else begin
        bubbles++;
      end
      step();
    end
    update = 1'b0;
    check("t6b_count", 32'(idx), 32'd256);
    check("t6b_bubbles", 32'(bubbles), 32'd15);
    check("t6b_done", 32'(done), 32'd1);
    check("t6b_valid", 32'(valid), 32'd0);
    check("t6b_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
